collision_detector: RTL

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/collision_detector.sv
// Bullet collision arbiter: latches the first bullet/alien (or bullet/shield) overlap in a
// frame, reports the kill and score at the next frame strobe, then locks out for some frames.
// Optional macro SHIELD_COLLISION_EN enables bullet/shield collisions.
module collision_detector #(
    parameter int SCREEN_CORDW   = 16,
    parameter int ALIEN_IDW      = 6,
    parameter int POINTS         = 10,
    parameter int LOCKOUT_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame,
    input  logic                 bullet_drawing,
    input  logic                 alien_drawing,
    input  logic [ALIEN_IDW-1:0] alien_id,
    input  logic                 shield_drawing,
    output logic                 bullet_hit,
    output logic                 kill_valid,
    output logic [ALIEN_IDW-1:0] kill_id,
    output logic [15:0]          score,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        PENDING = 2'd1,
        FLUSH   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    typedef enum logic {
        KIND_ALIEN  = 1'b0,
        KIND_SHIELD = 1'b1
    } kind_t;

    localparam int CNTW = (LOCKOUT_FRAMES < 1) ? 1 : $clog2(LOCKOUT_FRAMES + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LOCKOUT_FRAMES);

    state_t               r_state;
    kind_t                r_kind;
    logic [ALIEN_IDW-1:0] r_id;
    logic [CNTW-1:0]      r_cnt;
    logic                 r_bullet_hit;
    logic                 r_kill_valid;
    logic [ALIEN_IDW-1:0] r_kill_id;
    logic [15:0]          r_score;

    state_t               w_next;
    kind_t                w_kind_next;
    logic [ALIEN_IDW-1:0] w_id_next;
    logic [CNTW-1:0]      w_cnt_next;
    logic                 w_kill;
    logic                 w_alien_hit;
    logic                 w_shield_hit;
    logic [16:0]          w_score_sum;
    logic [15:0]          w_score_sat;
    logic                 w_unused;

    assign w_alien_hit = bullet_drawing & alien_drawing;
`ifdef SHIELD_COLLISION_EN
    assign w_shield_hit = bullet_drawing & shield_drawing;
`else
    assign w_shield_hit = 1'b0;
`endif
    assign w_unused = ^{shield_drawing, (SCREEN_CORDW > 0)};

    // Saturating add: score sticks at 16'hFFFF instead of wrapping.
    assign w_score_sum = {1'b0, r_score} + 17'(POINTS);
    assign w_score_sat = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

    always_comb begin
        w_next      = r_state;
        w_kind_next = r_kind;
        w_id_next   = r_id;
        w_cnt_next  = r_cnt;
        w_kill      = 1'b0;
        case (r_state)
            ARMED: begin
                // A frame strobe in the same cycle is ignored: the event waits for the next one.
                if (w_alien_hit) begin
                    w_next      = PENDING;
                    w_id_next   = alien_id;
                    w_kind_next = KIND_ALIEN;
                end else if (w_shield_hit) begin
                    w_next      = PENDING;
                    w_kind_next = KIND_SHIELD;
                end
            end
            PENDING: begin
                if (frame) begin
                    w_next = FLUSH;
                    w_kill = (r_kind == KIND_ALIEN);
                end
            end
            FLUSH: begin
                if (frame) begin
                    if (LOCKOUT_FRAMES == 0) begin
                        w_next = ARMED;
                    end else begin
                        w_next     = LOCKOUT;
                        w_cnt_next = CNT_LOAD;
                    end
                end
            end
            LOCKOUT: begin
                if (frame) begin
                    if (r_cnt <= CNTW'(1)) begin
                        w_next     = ARMED;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt - CNTW'(1);
                    end
                end
            end
            default: w_next = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARMED;
            r_kind       <= KIND_ALIEN;
            r_id         <= '0;
            r_cnt        <= '0;
            r_bullet_hit <= 1'b0;
            r_kill_valid <= 1'b0;
            r_kill_id    <= '0;
            r_score      <= '0;
        end else begin
            r_state      <= w_next;
            r_kind       <= w_kind_next;
            r_id         <= w_id_next;
            r_cnt        <= w_cnt_next;
            r_bullet_hit <= (w_next == PENDING) || (w_next == FLUSH);
            r_kill_valid <= w_kill;
            if (w_kill) begin
                r_kill_id <= r_id;
                r_score   <= w_score_sat;
            end
        end
    end

    assign bullet_hit = r_bullet_hit;
    assign kill_valid = r_kill_valid;
    assign kill_id    = r_kill_id;
    assign score      = r_score;
    assign dbg_state  = r_state;

endmodule
